jk_counter_sequencer: RTL and testbench
=======================================

Name: jk_counter_sequencer

Overview:
- Command-driven controller for a WIDTH-bit bank of external JK flip-flops, such as the 3-bit JK counter driven from a shared CLK with an LED readout.
- Generates the per-bit J/K drive that makes the bank hold, count up, count down or load a value, for a commanded number of clock edges.
- Tracks an expected bank value and flags any divergence from the bank's Q feedback.
- Sits between a command source (switch panel or upstream FSM) and the JK bank; the bank is clocked by the same CLK.

Parameters:
- WIDTH, 3, number of JK flip-flops in the controlled bank.
- LEN_W, 8, width of the step-count field.

Ports:
- CLK  input  1  single clock; all state updates on rising edge; the JK bank shares this clock.
- RESET  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  2  0=HOLD, 1=UP, 2=DOWN, 3=LOAD.
- cmd_data  input  WIDTH  load value (LOAD only).
- cmd_len  input  LEN_W  number of steps (UP/DOWN/HOLD); 0 is treated as 1.
- q_fb  input  WIDTH  Q outputs of the JK bank.
- J  output  WIDTH  J drive to the bank.
- K  output  WIDTH  K drive to the bank.
- busy  output  1  command in progress.
- done  output  1  one-cycle pulse on command completion.
- wrap  output  1  one-cycle pulse on any step where the count wraps (UP from all-ones, DOWN from zero).
- err  output  1  sticky mismatch flag between q_fb and the expected value.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; J=K=0; cmd_ready=1; busy=0; done=0; wrap=0; err=0; expected=0; step counter=0.
  - Reset asserted mid-command aborts it immediately; no done pulse.
- States: IDLE, RUN, LOAD, DONE.
- IDLE:
  - cmd_ready=1; J=K=0.
  - Handshake is cmd_valid & cmd_ready at an edge. On handshake, latch op, data and len (0→1).
  - LOAD goes to LOAD; any other op goes to RUN. Without a handshake, stay in IDLE.
- RUN:
  - cmd_ready=0; busy=1.
  - J/K are combinational from the latched op and q_fb, stable before the next edge:
    - UP: toggle mask t[0]=1, t[i]=&q_fb[i-1:0]; J=K=t.
    - DOWN: t[0]=1, t[i]=&~q_fb[i-1:0]; J=K=t.
    - HOLD: J=K=0.
  - Each edge in RUN: expected advances by +1, -1 or 0 (mod 2^WIDTH); step counter decrements.
  - wrap pulses in the cycle after a wrapping edge.
  - When the counter reaches 0 after the final step edge, go to DONE.
  - Latency: N steps occupy exactly N edges in RUN.
- LOAD:
  - One cycle with J=data and K=~data; expected=data at the edge; then go to DONE.
- DONE:
  - One cycle with J=K=0; done=1; busy=0; cmd_ready=0; then go to IDLE.
  - Back-to-back commands therefore have a minimum spacing of len+2 cycles.
- Error check:
  - In every cycle of RUN, DONE and IDLE after the first completed command, compare q_fb with expected.
  - Any mismatch sets err; err clears only on RESET.
  - The check is disabled from reset until the first LOAD, so the bank's power-up value is don't-care.
- cmd_valid while busy is ignored; the command is not lost as long as the source holds it until cmd_ready.
- Widths: expected and arithmetic are WIDTH bits with natural wrap. The step counter is LEN_W bits.

Test Plan:
- RESET pulse mid-RUN (UP, len=5, after 2 steps) → J=K=0, busy=0, no done, cmd_ready=1 immediately; err stays 0.
- LOAD data=3'b101 with behavioural JK bank → J=101, K=010 for 1 cycle, then q_fb=5, done pulse 2 cycles after handshake, err=0.
- After LOAD 6, UP len=3 → q_fb sequence 7,0,1; wrap pulses once after the 7→0 edge; done after step 3.
- After LOAD 1, DOWN len=2 → q_fb 0,7; J=K=001 on the first step, then J=K=111; wrap=1 once.
- HOLD len=0 → treated as 1 step, J=K=0, q_fb unchanged, done pulses; cmd_valid held during busy is accepted only when cmd_ready=1.
- Fault injection: force q_fb bit1 stuck-at-0 during UP len=4 from 0 → err sets at the first mismatch (expected 2) and stays set through further commands until RESET.

Source files
------------

// File: rtl/jk_counter_sequencer.sv
// Command-driven J/K sequencer for an external bank of JK flip-flops sharing CLK.
// Drives hold/up/down/load steps and flags divergence between Q feedback and the tracked value.
module jk_counter_sequencer #(
    parameter int WIDTH = 3,
    parameter int LEN_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_HOLD = 2'd0;
    localparam logic [1:0] OP_UP   = 2'd1;
    localparam logic [1:0] OP_DOWN = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'd3;

    logic [1:0]       state;
    logic [1:0]       op;
    logic [WIDTH-1:0] data;
    logic [LEN_W-1:0] cnt;
    logic [WIDTH-1:0] expected;
    logic             chk_en;
    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;

    // Ripple-style toggle masks: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic acc_up;
        logic acc_dn;
        acc_up = 1'b1;
        acc_dn = 1'b1;
        t_up   = '0;
        t_dn   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            t_up[i] = acc_up;
            t_dn[i] = acc_dn;
            acc_up  = acc_up & q_fb[i];
            acc_dn  = acc_dn & ~q_fb[i];
        end
    end

    always_comb begin
        J = '0;
        K = '0;
        if (state == S_RUN) begin
            if (op == OP_UP) begin
                J = t_up;
                K = t_up;
            end else if (op == OP_DOWN) begin
                J = t_dn;
                K = t_dn;
            end
        end else if (state == S_LOAD) begin
            J = data;
            K = ~data;
        end
    end

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state == S_RUN) || (state == S_LOAD);
    assign done      = (state == S_DONE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= S_IDLE;
            op       <= OP_HOLD;
            data     <= '0;
            cnt      <= '0;
            expected <= '0;
            chk_en   <= 1'b0;
            wrap     <= 1'b0;
            err      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            // The LOAD cycle is skipped: the bank still shows its pre-load value there.
            if (chk_en && (state != S_LOAD) && (q_fb != expected))
                err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op    <= cmd_op;
                        data  <= cmd_data;
                        cnt   <= (cmd_len == '0) ? LEN_W'(1) : cmd_len;
                        state <= (cmd_op == OP_LOAD) ? S_LOAD : S_RUN;
                    end
                end
                S_RUN: begin
                    if (op == OP_UP) begin
                        expected <= expected + WIDTH'(1);
                        wrap     <= (expected == '1);
                    end else if (op == OP_DOWN) begin
                        expected <= expected - WIDTH'(1);
                        wrap     <= (expected == '0);
                    end
                    cnt <= cnt - LEN_W'(1);
                    if (cnt <= LEN_W'(1))
                        state <= S_DONE;
                end
                S_LOAD: begin
                    expected <= data;
                    chk_en   <= 1'b1;
                    state    <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jk_counter_sequencer.sv
// Directed bench: a behavioural 3-bit JK bank closes the loop through q_fb,
// with an optional stuck-at-0 mask for the mismatch check.
module tb_jk_counter_sequencer;

    localparam logic [1:0] OP_HOLD = 2'd0;
    localparam logic [1:0] OP_UP   = 2'd1;
    localparam logic [1:0] OP_DOWN = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'd3;

    logic       CLK;
    logic       RESET;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_data;
    logic [7:0] cmd_len;
    logic [2:0] q_fb;
    logic [2:0] J;
    logic [2:0] K;
    logic       busy;
    logic       done;
    logic       wrap;
    logic       err;

    logic [2:0] bank;
    logic [2:0] stuck_n;
    int         total;
    int         bad;

    jk_counter_sequencer #(.WIDTH(3), .LEN_W(8)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .cmd_len  (cmd_len),
        .q_fb     (q_fb),
        .J        (J),
        .K        (K),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap),
        .err      (err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    assign q_fb = bank & stuck_n;

    always @(posedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            case ({J[i], K[i]})
                2'b10:   bank[i] <= 1'b1;
                2'b01:   bank[i] <= 1'b0;
                2'b11:   bank[i] <= ~bank[i];
                default: bank[i] <= bank[i];
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [2:0] d, input logic [7:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_len   = len;
        step(1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        bank      = 3'd0;
        stuck_n   = 3'b111;
        cmd_valid = 1'b0;
        cmd_op    = OP_HOLD;
        cmd_data  = 3'd0;
        cmd_len   = 8'd0;
        RESET     = 1'b1;
        step(2);
        check("rst_ready", cmd_ready, 1);
        check("rst_jk", {J, K}, 0);
        check("rst_flags", {busy, done, wrap, err}, 0);
        RESET = 1'b0;
        step(1);

        // UP len=5, reset after two steps
        send(OP_UP, 3'd0, 8'd5);
        check("up_busy", {busy, cmd_ready}, 2'b10);
        check("up_j0", J, 3'b001);
        step(2);
        check("up_mid_busy", busy, 1);
        #1 RESET = 1'b1;
        #1;
        check("abort_jk", {J, K}, 0);
        check("abort_flags", {busy, done, cmd_ready, err}, 4'b0010);
        step(1);
        RESET = 1'b0;
        step(1);
        check("abort_nodone", {done, busy, cmd_ready}, 3'b001);

        // LOAD 5
        send(OP_LOAD, 3'b101, 8'd0);
        check("ld_j", J, 3'b101);
        check("ld_k", K, 3'b010);
        check("ld_busy", busy, 1);
        step(1);
        check("ld_done", {done, busy, cmd_ready}, 3'b100);
        check("ld_q", q_fb, 5);
        step(1);
        check("ld_idle", {done, cmd_ready, err}, 3'b010);

        // LOAD 6, UP 3: 7,0,1
        send(OP_LOAD, 3'd6, 8'd0);
        step(2);
        send(OP_UP, 3'd0, 8'd3);
        check("u3_j0", {J, K}, 6'b001_001);
        step(1);
        check("u3_q1", {q_fb, wrap}, {3'd7, 1'b0});
        check("u3_j1", {J, K}, 6'b111_111);
        step(1);
        check("u3_q2", {q_fb, wrap, done}, {3'd0, 1'b1, 1'b0});
        step(1);
        check("u3_q3", {q_fb, wrap, done}, {3'd1, 1'b0, 1'b1});
        step(1);
        check("u3_end", {done, wrap, err, cmd_ready}, 4'b0001);

        // LOAD 1, DOWN 2: 0,7
        send(OP_LOAD, 3'd1, 8'd0);
        step(2);
        send(OP_DOWN, 3'd0, 8'd2);
        check("d2_j0", {J, K}, 6'b001_001);
        step(1);
        check("d2_q1", {q_fb, wrap}, {3'd0, 1'b0});
        check("d2_j1", {J, K}, 6'b111_111);
        step(1);
        check("d2_q2", {q_fb, wrap, done}, {3'd7, 1'b1, 1'b1});
        step(1);
        check("d2_end", {wrap, err}, 0);

        // HOLD len=0 with cmd_valid held throughout
        cmd_valid = 1'b1;
        cmd_op    = OP_HOLD;
        cmd_len   = 8'd0;
        step(1);
        check("h_busy", {busy, cmd_ready}, 2'b10);
        check("h_jk", {J, K}, 0);
        step(1);
        check("h_done", {done, busy, cmd_ready}, 3'b100);
        check("h_q", q_fb, 7);
        step(1);
        check("h_idle", {done, busy, cmd_ready}, 3'b001);
        step(1);
        check("h_reaccept", {busy, cmd_ready}, 2'b10);
        cmd_valid = 1'b0;
        step(2);
        check("h_end", {cmd_ready, err, q_fb}, {1'b1, 1'b0, 3'd7});

        // Stuck-at-0 on bit 1 during UP 4 from 0
        send(OP_LOAD, 3'd0, 8'd0);
        step(2);
        stuck_n = 3'b101;
        send(OP_UP, 3'd0, 8'd4);
        step(1);
        check("f_q1", {q_fb, err}, {3'd1, 1'b0});
        step(1);
        check("f_q2", {q_fb, err}, {3'd0, 1'b0});
        step(1);
        check("f_err", err, 1);
        step(2);
        stuck_n = 3'b111;
        send(OP_HOLD, 3'd0, 8'd1);
        step(3);
        check("f_sticky", {err, cmd_ready}, 2'b11);
        RESET = 1'b1;
        step(1);
        check("f_clear", err, 0);
        RESET = 1'b0;
        step(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
